uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Serial transmitter for the CPU-to-host link. It is the transmit end of the 8N1-style UART that the host-side receiver decodes.
- Accepts bytes from the I/O controller through a write-strobe interface and buffers them in an internal FIFO.
- Serializes the buffered bytes onto a single line at a fixed baud divisor: LSB first, optional parity bit, one stop bit.
- Sits between the memory-mapped I/O port logic and the top-level tx pin.

Parameters:
- BAUD_DIV, 868, clock cycles per serial bit (100 MHz / 115200); legal range ≥2.
- DATA_BITS, 8, data bits per frame; legal values 5 to 8.
- FIFO_AW, 4, log2 of FIFO depth (default depth is 16 entries).
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe; pushes wr_data when full=0.
- wr_data  in  DATA_BITS  byte to transmit.
- full  out  1  FIFO holds 2^FIFO_AW entries.
- empty  out  1  FIFO holds 0 entries.
- busy  out  1  high when the FSM is not in IDLE or empty=0.
- overflow  out  1  sticky; set when wr_en is asserted while full=1.
- tx  out  1  serial line, registered, idles high.

Behaviour:
- Reset values (applied asynchronously when rst_n=0):
  - tx=1, full=0, empty=1, busy=0, overflow=0.
  - FIFO pointers and count are 0. FSM is in IDLE. Baud counter is 0.
- FIFO:
  - Count width is FIFO_AW+1. Pointers wrap modulo 2^FIFO_AW.
  - A write is accepted iff wr_en=1 and full=0 at the clock edge.
  - A write while full is dropped and sets overflow. The write is rejected even if a pop occurs on the same edge.
  - A simultaneous accepted push and pop leaves the count unchanged.
  - full and empty are registered from the count and are valid in the cycle after the edge.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE:
  - tx=1.
  - If empty=0: pop the head entry into the shift register, load the baud counter with BAUD_DIV-1, drive tx=0, and go to START.
  - A byte written at edge N into an empty FIFO in IDLE drives tx low from edge N+2.
- START and every later bit:
  - tx is held for exactly BAUD_DIV cycles. The baud counter decrements each cycle.
  - When the counter reaches 0 it reloads BAUD_DIV-1 and the FSM advances to the next bit.
- DATA:
  - Sends shift[0] and shifts right each bit period, for DATA_BITS bits in total. Bit index counts 0 to DATA_BITS-1.
  - Running parity is the XOR of the data bits.
  - Next state is PAR if PARITY≠0, otherwise STOP.
- PAR:
  - tx = XOR of the data bits for even parity, or its inversion for odd parity.
- STOP:
  - tx=1 for BAUD_DIV cycles.
  - At the end of the bit, if empty=0 the FSM pops the next byte and enters START directly, with no idle gap between frames. Otherwise it goes to IDLE.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + 1) × BAUD_DIV cycles.
- overflow clears only on reset.
- Reset asserted mid-frame:
  - tx returns to 1 immediately (asynchronously).
  - The FIFO contents are discarded and the partial frame is abandoned.
  - After rst_n deasserts there is no glitch on tx.
- Writes during transmission are accepted normally while full=0 and never disturb the frame in flight.

Test Plan:
- Single byte: BAUD_DIV=4, PARITY=0, write 0xA5 → tx pattern 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each bit 4 cycles. Tx falls 2 edges after the write, busy stays high for 40 cycles, then busy=0 and tx=1.
- Back-to-back: write 0x00 then 0xFF on consecutive cycles → two 40-cycle frames. The second start bit begins the cycle after the first stop bit ends, and tx is never high for more than 4 cycles between frames.
- Parity: PARITY=1, write 0x07 → parity bit 1. PARITY=2, write 0x07 → parity bit 0. Frame is 44 cycles.
- Full/overflow: FIFO_AW=2, BAUD_DIV=16:
  - Write 6 bytes in 6 consecutive cycles → the first byte is popped; the next 4 fill the FIFO, and full=1 follows.
  - The 6th write is dropped and overflow=1.
  - Exactly 5 frames are sent.
- Full with simultaneous pop: hold the FIFO full and assert wr_en on the edge where STOP pops → write rejected, count drops by 1, overflow=1.
- Reset mid-frame: drop rst_n during the DATA bit 3 period → tx=1 within the same cycle, empty=1, busy=0. After release, writing 0x3C produces a clean complete frame.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal write FIFO: start bit, LSB-first data, optional parity, one stop bit.
// Bytes are pushed through a write strobe and leave on tx at BAUD_DIV clocks per bit.
module uart_tx_fifo #(
  parameter int BAUD_DIV  = 868,
  parameter int DATA_BITS = 8,
  parameter int FIFO_AW   = 4,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic                 busy,
  output logic                 overflow,
  output logic                 tx
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNTW  = FIFO_AW + 1;
  localparam int CW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]   RELOAD   = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
  localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] CNT_NONE = CNTW'(0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  logic [DATA_BITS-1:0] mem_r [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_r;
  logic [FIFO_AW-1:0]   rd_ptr_r;
  logic [CNTW-1:0]      count_r;
  logic [CNTW-1:0]      count_next_s;
  logic                 full_r;
  logic                 empty_r;
  logic                 overflow_r;
  logic                 push_s;
  logic                 pop_s;

  state_t               state_r;
  logic [CW-1:0]        baud_r;
  logic [2:0]           bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_r;
  logic                 tx_r;

  // Line value of the parity bit given the XOR of the data bits.
  function automatic logic parity_bit(input logic data_xor);
    if (PARITY == 2) begin
      return ~data_xor;
    end else begin
      return data_xor;
    end
  endfunction

  // Push/pop qualification and next FIFO occupancy.
  always_comb begin
    push_s = wr_en & ~full_r;
    if (!empty_r && ((state_r == S_IDLE) || ((state_r == S_STOP) && (baud_r == CNT_ZERO)))) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNTW'(1);
      2'b01:   count_next_s = count_r - CNTW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage; contents need no reset since the count guards every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // FIFO pointers, occupancy flags and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= CNT_NONE;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_FULL);
      // empty follows the committed count, so a fresh byte is popped two edges after its write
      empty_r <= (count_r == CNT_NONE);
      if (wr_en && full_r) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Frame sequencer: every bit is held for BAUD_DIV cycles, tx is driven from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      baud_r    <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= '0;
      par_r     <= 1'b0;
      tx_r      <= 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          tx_r <= 1'b1;
          if (pop_s) begin
            shift_r <= mem_r[rd_ptr_r];
            baud_r  <= RELOAD;
            par_r   <= 1'b0;
            tx_r    <= 1'b0;
            state_r <= S_START;
          end
        end
        S_START: begin
          if (baud_r == CNT_ZERO) begin
            baud_r    <= RELOAD;
            bit_idx_r <= 3'd0;
            tx_r      <= shift_r[0];
            state_r   <= S_DATA;
          end else begin
            baud_r <= baud_r - CW'(1);
          end
        end
        S_DATA: begin
          if (baud_r == CNT_ZERO) begin
            baud_r  <= RELOAD;
            shift_r <= shift_r >> 1;
            par_r   <= par_r ^ shift_r[0];
            if (bit_idx_r == LAST_BIT) begin
              if (PARITY != 0) begin
                tx_r    <= parity_bit(par_r ^ shift_r[0]);
                state_r <= S_PAR;
              end else begin
                tx_r    <= 1'b1;
                state_r <= S_STOP;
              end
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= shift_r[1];
            end
          end else begin
            baud_r <= baud_r - CW'(1);
          end
        end
        S_PAR: begin
          if (baud_r == CNT_ZERO) begin
            baud_r  <= RELOAD;
            tx_r    <= 1'b1;
            state_r <= S_STOP;
          end else begin
            baud_r <= baud_r - CW'(1);
          end
        end
        S_STOP: begin
          if (baud_r == CNT_ZERO) begin
            // a queued byte starts immediately, no idle bit between frames
            if (pop_s) begin
              shift_r <= mem_r[rd_ptr_r];
              baud_r  <= RELOAD;
              par_r   <= 1'b0;
              tx_r    <= 1'b0;
              state_r <= S_START;
            end else begin
              tx_r    <= 1'b1;
              state_r <= S_IDLE;
            end
          end else begin
            baud_r <= baud_r - CW'(1);
          end
        end
        default: begin
          tx_r    <= 1'b1;
          baud_r  <= CNT_ZERO;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign full     = full_r;
  assign empty    = empty_r;
  assign overflow = overflow_r;
  assign busy     = (state_r != S_IDLE) | ~empty_r;
  assign tx       = tx_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover plain, even/odd parity and a shallow FIFO.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] we;
  logic [7:0] wd [4];
  logic [3:0] tx, busy, full, empty, ovf;

  logic [127:0] tv [4];
  logic [127:0] bv [4];
  logic [7:0]   got [8];
  int           n_checks = 0;
  int           n_pass = 0;
  int           nfr;
  int           bad_fmt;

  always #5 clk = ~clk;

  uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(8), .FIFO_AW(4), .PARITY(0)) u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(we[0]), .wr_data(wd[0]), .full(full[0]),
    .empty(empty[0]), .busy(busy[0]), .overflow(ovf[0]), .tx(tx[0]));
  uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(8), .FIFO_AW(4), .PARITY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(we[1]), .wr_data(wd[1]), .full(full[1]),
    .empty(empty[1]), .busy(busy[1]), .overflow(ovf[1]), .tx(tx[1]));
  uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(8), .FIFO_AW(4), .PARITY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .wr_en(we[2]), .wr_data(wd[2]), .full(full[2]),
    .empty(empty[2]), .busy(busy[2]), .overflow(ovf[2]), .tx(tx[2]));
  uart_tx_fifo #(.BAUD_DIV(16), .DATA_BITS(8), .FIFO_AW(2), .PARITY(0)) u3 (
    .clk(clk), .rst_n(rst_n), .wr_en(we[3]), .wr_data(wd[3]), .full(full[3]),
    .empty(empty[3]), .busy(busy[3]), .overflow(ovf[3]), .tx(tx[3]));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line bits of one frame, start bit in bit 0.
  function automatic logic [15:0] frame(input logic [7:0] d, input int haspar, input logic p);
    if (haspar != 0) return {5'd0, 1'b1, p, d, 1'b0};
    else             return {6'd0, 1'b1, d, 1'b0};
  endfunction

  // Per-cycle waveform: bit i of the result is the line value in cycle i.
  function automatic logic [127:0] expand(input logic [15:0] bits, input int nb, input int bd);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < nb * bd; i++) v[i] = bits[i / bd];
    return v;
  endfunction

  function automatic logic [127:0] ones(input int n);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic grab(input int n);
    for (int k = 0; k < 4; k++) begin
      tv[k] = '0;
      bv[k] = '0;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        tv[k][i] = tx[k];
        bv[k][i] = busy[k];
      end
    end
  endtask

  task automatic decode_u3();
    logic [7:0] b;
    int w;
    bit done;
    done = 1'b0;
    nfr = 0;
    bad_fmt = 0;
    while (!done) begin
      w = 0;
      while (tx[3] !== 1'b0 && w < 400) begin
        @(negedge clk);
        w++;
      end
      if (w >= 400) begin
        done = 1'b1;
      end else begin
        repeat (8) @(negedge clk);
        if (tx[3] !== 1'b0) bad_fmt++;
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          b[i] = tx[3];
        end
        repeat (16) @(negedge clk);
        if (tx[3] !== 1'b1) bad_fmt++;
        if (nfr < 8) got[nfr] = b;
        nfr++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    we = 4'h0;
    for (int k = 0; k < 4; k++) wd[k] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 4'hF);
    check("rst_empty", empty, 4'hF);
    check("rst_full", full, 4'h0);
    check("rst_busy", busy, 4'h0);
    check("rst_ovf", ovf, 4'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single byte 0xA5
    we[0] = 1'b1; wd[0] = 8'hA5;
    @(negedge clk);
    we[0] = 1'b0;
    check("single_tx_e0", tx[0], 1'b1);
    check("single_busy_e0", busy[0], 1'b0);
    @(negedge clk);
    check("single_tx_e1", tx[0], 1'b1);
    check("single_busy_e1", busy[0], 1'b1);
    grab(40);
    check("single_frame", tv[0], expand(frame(8'hA5, 0, 1'b0), 10, 4));
    check("single_busy", bv[0], ones(40));
    @(negedge clk);
    check("single_tx_end", tx[0], 1'b1);
    check("single_busy_end", busy[0], 1'b0);

    // back-to-back 0x00 then 0xFF
    repeat (3) @(negedge clk);
    we[0] = 1'b1; wd[0] = 8'h00;
    @(negedge clk);
    wd[0] = 8'hFF;
    @(negedge clk);
    we[0] = 1'b0;
    grab(80);
    check("b2b_frames", tv[0],
          expand(frame(8'h00, 0, 1'b0), 10, 4) | (expand(frame(8'hFF, 0, 1'b0), 10, 4) << 40));
    @(negedge clk);
    check("b2b_tx_end", tx[0], 1'b1);
    check("b2b_busy_end", busy[0], 1'b0);

    // parity: even and odd on 0x07 (three ones)
    we[1] = 1'b1; we[2] = 1'b1; wd[1] = 8'h07; wd[2] = 8'h07;
    @(negedge clk);
    we[1] = 1'b0; we[2] = 1'b0;
    @(negedge clk);
    grab(44);
    check("par_even_frame", tv[1], expand(frame(8'h07, 1, 1'b1), 11, 4));
    check("par_odd_frame", tv[2], expand(frame(8'h07, 1, 1'b0), 11, 4));
    @(negedge clk);
    check("par_tx_end", {tx[2], tx[1]}, 2'b11);

    // shallow FIFO: fill, overflow, and a write on the popping edge
    fork
      decode_u3();
      begin
        for (int i = 0; i < 6; i++) begin
          we[3] = 1'b1;
          wd[3] = 8'(8'h11 * (i + 1));
          @(negedge clk);
          if (i == 4) begin
            check("fifo_full_after5", full[3], 1'b1);
            check("fifo_noovf_after5", ovf[3], 1'b0);
          end
        end
        we[3] = 1'b0;
        check("fifo_ovf_after6", ovf[3], 1'b1);
        check("fifo_full_after6", full[3], 1'b1);
        repeat (156) @(negedge clk);
        check("fifo_full_prepop", full[3], 1'b1);
        we[3] = 1'b1; wd[3] = 8'h77;
        @(negedge clk);
        we[3] = 1'b0;
        check("fifo_full_postpop", full[3], 1'b0);
        check("fifo_ovf_postpop", ovf[3], 1'b1);
      end
    join
    check("fifo_nframes", nfr, 5);
    check("fifo_format", bad_fmt, 0);
    for (int i = 0; i < 5; i++) check("fifo_byte", got[i], 8'(8'h11 * (i + 1)));

    // reset during data bit 3 of 0x81
    we[0] = 1'b1; wd[0] = 8'h81;
    @(negedge clk);
    we[0] = 1'b0;
    repeat (19) @(negedge clk);
    check("rstmid_pre_tx", tx[0], 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_tx", tx[0], 1'b1);
    check("rstmid_empty", empty[0], 1'b1);
    check("rstmid_busy", busy[0], 1'b0);
    check("rstmid_ovf_cleared", ovf[3], 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    grab(10);
    check("rstmid_idle_tx", tv[0], ones(10));
    check("rstmid_idle_busy", bv[0], 128'd0);
    we[0] = 1'b1; wd[0] = 8'h3C;
    @(negedge clk);
    we[0] = 1'b0;
    @(negedge clk);
    grab(40);
    check("rstmid_frame", tv[0], expand(frame(8'h3C, 0, 1'b0), 10, 4));
    @(negedge clk);
    check("rstmid_tx_end", tx[0], 1'b1);
    check("rstmid_busy_end", busy[0], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
